psum_requant: RTL and testbench
===============================

// Module: psum_requant
// PURPOSE
//  Downstream of the pipelined adder tree in the conv compute path. Accumulates per-tile
//  partial sums over a configurable number of input-channel tiles, adds per-channel bias,
//  requantizes (multiply, rounding right shift, zero-point add) and saturates to int8.
//  Feeds the output writer. Free-running stream; no backpressure, like its producer.
// PARAMETERS
//  ACC_W      48  width of incoming partial sums and internal accumulator (signed)
//  OUT_W      8   width of quantized output (signed)
//  BIAS_W     32  width of bias (signed)
//  MULT_W     32  width of requant multiplier (unsigned)
//  TILE_W     8   width of tile-count config
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous active-high reset
//  valid_in        in   1        sum_in valid this cycle (one beat per tile)
//  sum_in          in   ACC_W    signed partial sum from adder tree
//  cfg_num_tiles   in   TILE_W   beats per output group; 0 treated as 1
//  cfg_bias        in   BIAS_W   signed bias, sign-extended to ACC_W
//  cfg_mult        in   MULT_W   unsigned requant multiplier
//  cfg_shift       in   6        right-shift amount 0..63
//  cfg_zp          in   OUT_W    signed output zero point
//  out_valid       out  1        out_data valid, single-cycle pulse per group
//  out_data        out  OUT_W    signed quantized result
//  busy            out  1        group in progress or result in flight
//  err_ovf         out  1        sticky: accumulator saturated at least once
// BEHAVIOUR
//  - Reset (sync): state IDLE, tile cnt=0, acc=0, all stage valids=0; out_valid=0,
//    out_data=0, busy=0, err_ovf=0. In-flight group discarded; no out_valid follows.
//  - FSM IDLE/ACCUM. IDLE & valid_in: latch all cfg_*, acc<=sum_in, cnt<=1; cfg changes
//    mid-group ignored. ACCUM & valid_in: acc<=sat(acc+sum_in), cnt++. valid_in low: hold.
//  - Last beat (cnt+1==num_tiles, incl. num_tiles<=1 on first beat): register
//    S0=sat(acc_final+bias), return to IDLE same edge; next group's first beat accepted
//    the following cycle (back-to-back groups at full rate).
//  - Accum saturates to ACC_W signed range (never wraps); any clamp sets err_ovf.
//  - S1: p = S0 * $signed({1'b0,mult}), width ACC_W+MULT_W+1, exact.
//  - S2: shift==0 -> p; else (p + (1<<(shift-1))) >>> shift (round half toward +inf).
//  - S3: q = S2 + zp; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] -> out_data, out_valid=1.
//  - Latency: out_valid rises 4 clocks after the edge that captures the last beat.
//  - out_data holds last value when out_valid=0.
//  - busy = (state==ACCUM) | any S0..S2 valid | out_valid.
// CONFIGURATION
//  PSUM_RELU_EN defined: S3 additionally clamps q below at zp (ReLU in quantized domain).
//  Undefined: no lower clamp beyond int saturation. Latency identical either way.
// STRUCTURE
//  Shared package (mobilenet_pkg): ACC_W/OUT_W defaults, sat_signed() and
//  round_shift() functions, requant cfg struct typedef.
//  Sub-module requant_pipe: stages S1..S3 (mult, round-shift, zp/saturate/ReLU), with
//  its own valid chain; psum_requant holds FSM, counter, accumulator, S0, err_ovf.
// TESTING
//  1 tiles=1,bias=0,mult=1,shift=0,zp=0, sum_in=5 -> out_data=5, out_valid 1 cycle, 4 clk later
//  2 tiles=3, sums 100,200,-50, bias=10, mult=1, shift=2 -> acc 260, out_data=65
//  3 tiles=1, sum_in=-1000, mult=1, shift=0, zp=0 -> -128; with PSUM_RELU_EN -> 0;
//    sum_in=6,shift=2 -> 2; sum_in=-6,shift=2 -> -1
//  4 tiles=1, valid_in 3 consecutive cycles sums 1,2,3 -> out_data 1,2,3 on consecutive cycles
//  5 tiles=2, sum_in=2^47-1 twice -> acc clamps at 2^47-1, err_ovf=1 and stays 1 until rst
//  6 tiles=4, 2 beats then rst 1 cycle -> no out_valid, busy=0; next group tiles=1 sum 7 -> 7

Source files
------------

// File: rtl/mobilenet_pkg.sv
// Shared widths, requant config struct and saturate / rounding-shift helpers
// for the conv output path (partial-sum accumulate -> requantize -> int8).
package mobilenet_pkg;

  localparam int ACC_W  = 48;
  localparam int OUT_W  = 8;
  localparam int BIAS_W = 32;
  localparam int MULT_W = 32;
  localparam int TILE_W = 8;
  // exact product of signed acc and zero-extended unsigned multiplier
  localparam int P_W    = ACC_W + MULT_W + 1;
  localparam int Q_W    = P_W + 1;

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  typedef struct packed {
    logic [MULT_W-1:0]       mult;
    logic [5:0]              shift;
    logic signed [OUT_W-1:0] zp;
  } requant_cfg_t;

  function automatic logic acc_ovf(input logic signed [ACC_W:0] x);
    return x[ACC_W] ^ x[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_signed(input logic signed [ACC_W:0] x);
    if (!acc_ovf(x)) return x[ACC_W-1:0];
    return x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [Q_W-1:0] x);
    if ((&x[Q_W-1:OUT_W-1]) || !(|x[Q_W-1:OUT_W-1])) return x[OUT_W-1:0];
    return x[Q_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // round half toward +inf: add half an LSB of the result, then floor-shift
  function automatic logic signed [P_W-1:0] round_shift(input logic signed [P_W-1:0] p,
                                                        input logic [5:0] sh);
    logic signed [P_W-1:0] rnd;
    if (sh == 6'd0) return p;
    rnd = P_W'(1) << (sh - 6'd1);
    return (p + rnd) >>> sh;
  endfunction

endpackage

// File: rtl/requant_pipe.sv
// Requantize back end: multiply, rounding right shift, zero-point add and int8
// saturation. Optional macro PSUM_RELU_EN clamps the result below at zp.
module requant_pipe
  import mobilenet_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic signed [ACC_W-1:0] i_s0,
  input  requant_cfg_t            i_cfg,
  output logic                    o_valid,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_busy
);

  localparam int STAGES = 4;

  logic [STAGES:1]         r_vld_pipe;
  logic signed [P_W-1:0]   w_a, w_b, r_p, r_r;
  logic signed [Q_W-1:0]   r_q;
  logic [5:0]              r_sh1;
  logic signed [OUT_W-1:0] r_zp1, r_zp2, w_sat, w_res;
`ifdef PSUM_RELU_EN
  logic signed [OUT_W-1:0] r_zp3;
`endif

  assign w_a = P_W'(i_s0);
  assign w_b = P_W'($signed({1'b0, i_cfg.mult}));

  always_ff @(posedge clk) begin
    if (rst) r_vld_pipe <= '0;
    else     r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_vld};
  end

  // datapath registers free-run; only the valid chain qualifies them
  always_ff @(posedge clk) begin
    r_p   <= w_a * w_b;
    r_sh1 <= i_cfg.shift;
    r_zp1 <= i_cfg.zp;
    r_r   <= round_shift(r_p, r_sh1);
    r_zp2 <= r_zp1;
    r_q   <= {{(Q_W-P_W){r_r[P_W-1]}}, r_r} + {{(Q_W-OUT_W){r_zp2[OUT_W-1]}}, r_zp2};
`ifdef PSUM_RELU_EN
    r_zp3 <= r_zp2;
`endif
  end

  assign w_sat = sat_out(r_q);

  always_comb begin
    w_res = w_sat;
`ifdef PSUM_RELU_EN
    if (w_sat < r_zp3) w_res = r_zp3;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)                         o_data <= '0;
    else if (r_vld_pipe[STAGES-1])   o_data <= w_res;
  end

  assign o_valid = r_vld_pipe[STAGES];
  assign o_busy  = |r_vld_pipe;

endmodule

// File: rtl/psum_requant.sv
// Accumulates per-tile partial sums into one group result, adds bias and hands
// the saturated sum to requant_pipe (PSUM_RELU_EN selects quantized ReLU there).
module psum_requant
  import mobilenet_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [ACC_W-1:0]  sum_in,
  input  logic [TILE_W-1:0]        cfg_num_tiles,
  input  logic signed [BIAS_W-1:0] cfg_bias,
  input  logic [MULT_W-1:0]        cfg_mult,
  input  logic [5:0]               cfg_shift,
  input  logic signed [OUT_W-1:0]  cfg_zp,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy,
  output logic                     err_ovf
);

  state_t                   r_state, w_state_nx;
  logic [TILE_W-1:0]        r_cnt, r_tiles, w_tiles;
  logic [TILE_W:0]          w_cnt_nx;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nx, r_s0;
  logic signed [ACC_W:0]    w_acc_sum, w_s0_sum;
  logic signed [BIAS_W-1:0] r_bias, w_bias;
  requant_cfg_t             r_rq, w_rq, r_s0_rq;
  logic                     w_first, w_last, r_s0_vld, r_err, w_pipe_busy;

  // first beat of a group uses live cfg; later beats use the copy latched then
  assign w_first  = (r_state == ST_IDLE);
  assign w_tiles  = w_first ? cfg_num_tiles : r_tiles;
  assign w_bias   = w_first ? cfg_bias : r_bias;
  assign w_rq     = w_first ? {cfg_mult, cfg_shift, cfg_zp} : r_rq;
  assign w_cnt_nx = w_first ? (TILE_W+1)'(1) : {1'b0, r_cnt} + 1'b1;
  // >= folds num_tiles of 0 and 1 into a single-beat group
  assign w_last   = valid_in && (w_cnt_nx >= {1'b0, w_tiles});

  assign w_acc_sum = {r_acc[ACC_W-1], r_acc} + {sum_in[ACC_W-1], sum_in};
  assign w_acc_nx  = w_first ? sum_in : sat_signed(w_acc_sum);
  assign w_s0_sum  = {w_acc_nx[ACC_W-1], w_acc_nx}
                   + {{(ACC_W+1-BIAS_W){w_bias[BIAS_W-1]}}, w_bias};

  always_comb begin
    w_state_nx = r_state;
    if (valid_in) w_state_nx = w_last ? ST_IDLE : ST_ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_s0_vld <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_s0_vld <= w_last;
      if (valid_in) begin
        r_acc <= w_acc_nx;
        r_cnt <= w_cnt_nx[TILE_W-1:0];
        if ((!w_first && acc_ovf(w_acc_sum)) || (w_last && acc_ovf(w_s0_sum)))
          r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in && w_first) begin
      r_tiles <= cfg_num_tiles;
      r_bias  <= cfg_bias;
      r_rq    <= w_rq;
    end
    if (w_last) begin
      r_s0    <= sat_signed(w_s0_sum);
      r_s0_rq <= w_rq;
    end
  end

  requant_pipe u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (r_s0_vld),
    .i_s0    (r_s0),
    .i_cfg   (r_s0_rq),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_busy  (w_pipe_busy)
  );

  assign busy    = (r_state == ST_ACCUM) || r_s0_vld || w_pipe_busy;
  assign err_ovf = r_err;

endmodule

// File: tb/tb_psum_requant.sv
// Random + directed bench for psum_requant: issued groups push expected results
// (from a wide-integer arithmetic model) into a scoreboard drained by a monitor.
module tb_psum_requant;

  logic               clk = 1'b0, rst = 1'b1, valid_in = 1'b0;
  logic signed [47:0] sum_in = '0;
  logic [7:0]         cfg_num_tiles = '0;
  logic signed [31:0] cfg_bias = '0;
  logic [31:0]        cfg_mult = '0;
  logic [5:0]         cfg_shift = '0;
  logic signed [7:0]  cfg_zp = '0;
  logic               out_valid, busy, err_ovf;
  logic signed [7:0]  out_data;

  psum_requant dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sum_in(sum_in),
    .cfg_num_tiles(cfg_num_tiles), .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .cfg_zp(cfg_zp), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; int due; } exp_t;
  exp_t   sb[$];
  exp_t   mon_e;
  longint sq[$];
  int     n_tests = 0, n_fail = 0;
  bit     m_err = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [127:0] lim(input int w);
    return (128'sd1 <<< (w - 1)) - 1;
  endfunction

  function automatic bit fits(input logic signed [127:0] x, input int w);
    return (x <= lim(w)) && (x >= -lim(w) - 1);
  endfunction

  function automatic logic signed [127:0] clip(input logic signed [127:0] x, input int w);
    if (x > lim(w)) return lim(w);
    if (x < -lim(w) - 1) return -lim(w) - 1;
    return x;
  endfunction

  // Reference: saturating sum of beats, bias, exact product, rounded shift, zp, int8 clamp.
  function automatic int model(input longint s[$], input longint bias, input logic [31:0] mult,
                               input int sh, input int zp, output bit ovf);
    logic signed [127:0] acc, t, p, r, q;
    ovf = 1'b0;
    acc = s[0];
    for (int i = 1; i < s.size(); i++) begin
      t = acc + s[i];
      if (!fits(t, 48)) ovf = 1'b1;
      acc = clip(t, 48);
    end
    t = acc + bias;
    if (!fits(t, 48)) ovf = 1'b1;
    acc = clip(t, 48);
    p = acc * $signed({96'd0, mult});
    if (sh == 0) r = p;
    else         r = (p + (128'sd1 <<< (sh - 1))) >>> sh;
    q = clip(r + zp, 8);
`ifdef PSUM_RELU_EN
    if (q < zp) q = zp;
`endif
    return int'(q);
  endfunction

  task automatic scramble_cfg();
    cfg_num_tiles = 8'($urandom);
    cfg_bias      = 32'($urandom);
    cfg_mult      = $urandom;
    cfg_shift     = 6'($urandom);
    cfg_zp        = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      scramble_cfg();
    end
  endtask

  // Consumes beats from sq; cfg is presented only on the first beat.
  task automatic run_group(input int tiles, input longint bias, input logic [31:0] mult,
                           input int sh, input int zp, input bit gaps);
    longint s[$];
    longint v;
    int     n, e;
    bit     ovf;
    n = (tiles == 0) ? 1 : tiles;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) idle($urandom_range(2));
      @(negedge clk);
      v = sq.pop_front();
      s.push_back(v);
      valid_in = 1'b1;
      sum_in   = v[47:0];
      if (i == 0) begin
        cfg_num_tiles = tiles[7:0];
        cfg_bias      = bias[31:0];
        cfg_mult      = mult;
        cfg_shift     = sh[5:0];
        cfg_zp        = zp[7:0];
      end else scramble_cfg();
      if (i == n - 1) begin
        e = model(s, bias, mult, sh, zp, ovf);
        if (ovf) m_err = 1'b1;
        sb.push_back('{e, cyc + 5});
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid with out_data %0d, required no output", out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.data);
        chk("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  initial begin
    longint v, top;
    int     t, n, mode, sh, zp;
    longint b;
    logic [31:0] m;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ovf", err_ovf, 0);
    rst = 1'b0;

    sq = '{5};                 run_group(1, 0, 1, 0, 0, 0);  idle(8);
    sq = '{100, 200, -50};     run_group(3, 10, 1, 2, 0, 0); idle(8);
    sq = '{-1000, 6, -6};
    run_group(1, 0, 1, 0, 0, 0);
    run_group(1, 0, 1, 2, 0, 0);
    run_group(1, 0, 1, 2, 0, 0);
    idle(8);
    sq = '{1, 2, 3};
    repeat (3) run_group(1, 0, 1, 0, 0, 0);
    idle(8);
    chk("err_before_ovf", err_ovf, 0);

    top = (64'sd1 <<< 47) - 1;
    sq = '{top, top};          run_group(2, 0, 1, 0, 0, 0);  idle(8);
    chk("err_after_ovf", err_ovf, 1);
    sq = '{3};                 run_group(1, 0, 1, 0, 0, 0);  idle(8);
    chk("err_sticky", err_ovf, 1);

    // abandon a 4-tile group after two beats
    @(negedge clk); valid_in = 1'b1; sum_in = 48'sd11; cfg_num_tiles = 8'd4;
    cfg_bias = '0; cfg_mult = 32'd1; cfg_shift = '0; cfg_zp = '0;
    @(negedge clk); sum_in = 48'sd22;
    @(negedge clk); valid_in = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_err = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_err_cleared", err_ovf, 0);
    idle(8);
    sq = '{7};                 run_group(1, 0, 1, 0, 0, 0);  idle(8);
    chk("idle_busy", busy, 0);

    for (int g = 0; g < 300; g++) begin
      t    = $urandom_range(5);
      n    = (t == 0) ? 1 : t;
      mode = $urandom_range(3);
      for (int i = 0; i < n; i++) begin
        case (mode)
          0:       v = longint'($urandom_range(4000)) - 2000;
          1:       v = $signed({$urandom, $urandom}) >>> 16;
          2:       v = $urandom_range(1) ? top - $urandom_range(100) : -top - 1 + $urandom_range(100);
          default: v = $signed({$urandom, $urandom}) >>> 30;
        endcase
        sq.push_back(v);
      end
      if (mode == 0) begin
        m  = $urandom_range(8, 1);
        sh = $urandom_range(4);
        b  = longint'($urandom_range(200)) - 100;
      end else begin
        m  = $urandom;
        sh = $urandom_range(63, 40);
        b  = longint'($signed($urandom));
      end
      zp = int'($urandom_range(255)) - 128;
      run_group(t, b, m, sh, zp, $urandom_range(3) == 0);
      if ($urandom_range(4) == 0) idle($urandom_range(3, 1));
    end

    idle(10);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_busy", busy, 0);
    chk("final_err_ovf", err_ovf, m_err);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
